// File: rtl/count_sched_pkg.sv
// Shared definitions for the two-requester count scheduler and its
// six-state sequence counter.
package count_sched_pkg;

    // Default sizing: two requesters, up to seven steps per grant
    localparam int NREQ_DEF   = 2;
    localparam int STEP_W_DEF = 3;

    // Scheduler state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The six codes of the counter, in sequence order
    localparam logic [2:0] SEQ_C0 = 3'b000;
    localparam logic [2:0] SEQ_C1 = 3'b001;
    localparam logic [2:0] SEQ_C2 = 3'b011;
    localparam logic [2:0] SEQ_C3 = 3'b101;
    localparam logic [2:0] SEQ_C4 = 3'b111;
    localparam logic [2:0] SEQ_C5 = 3'b010;

    // Successor code; any off-sequence code recovers to 000
    function automatic logic [2:0] seq_next(input logic [2:0] cur);
        logic [2:0] nxt;
        case (cur)
            SEQ_C0:  nxt = SEQ_C1;
            SEQ_C1:  nxt = SEQ_C2;
            SEQ_C2:  nxt = SEQ_C3;
            SEQ_C3:  nxt = SEQ_C4;
            SEQ_C4:  nxt = SEQ_C5;
            SEQ_C5:  nxt = SEQ_C0;
            default: nxt = SEQ_C0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/count_sched_seq.sv
// The shared 3-bit six-state sequence counter driven by the scheduler.
module count_seq
    import count_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [2:0] q_o
);

    logic [2:0] code_q;
    logic [2:0] code_d;

    // Clear dominates; otherwise step one code whenever enabled
    always_comb begin
        code_d = code_q;
        if (clr_i) begin
            code_d = SEQ_C0;
        end else if (en_i) begin
            code_d = seq_next(code_q);
        end
    end

    // Counter register; its only reset path is the clear input
    always_ff @(posedge clk_i) begin
        code_q <= code_d;
    end

    assign q_o = code_q;

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler that owns the sequence counter: grants one of two
// requesters, steps the counter the requested number of times, then pulses
// done. Also provides an idle-time clear of the counter.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    input  logic              clr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cnt_en,
    output logic [2:0]        Q
);

    localparam logic [NREQ-1:0] GNT_R0 = NREQ'(1);
    localparam logic [NREQ-1:0] GNT_R1 = NREQ'(2);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              ptr_q, ptr_d;

    logic              clr_take;
    logic              who;
    logic              win;
    logic [STEP_W-1:0] steps_sel;
    logic              seq_clr;

    // Index of the current grantee, recovered from the one-hot grant
    assign who = gnt_q[1];

    // Next-state logic for arbitration, step countdown and completion
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        clr_take    = 1'b0;
        win         = 1'b0;
        steps_sel   = '0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    clr_take = 1'b1;
                end else if (|req) begin
                    win         = req[ptr_q] ? ptr_q : ~ptr_q;
                    steps_sel   = win ? steps1 : steps0;
                    remaining_d = steps_sel;
                    gnt_d       = win ? GNT_R1 : GNT_R0;
                    state_d     = (steps_sel == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                remaining_d = remaining_q - 1'b1;
                if (!req[who]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ~who;
                end else if (remaining_q == STEP_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ~who;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Scheduler registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            gnt_q       <= '0;
            ptr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = (state_q == ST_DONE) ? gnt_q : '0;
    assign busy   = (state_q != ST_IDLE);
    assign cnt_en = (state_q == ST_RUN);

    // Counter clears on block reset or on an accepted idle clear
    assign seq_clr = ~reset | clr_take;

    count_seq u_seq (
        .clk_i (clk),
        .clr_i (seq_clr),
        .en_i  (cnt_en),
        .q_o   (Q)
    );

endmodule

// File: tb/tb_count_sched.sv
// Randomized bench for count_sched against a grant-level reference model.
module tb_count_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [2:0] steps0;
    logic [2:0] steps1;
    logic       clr;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       cntEn;
    logic [2:0] q;

    int checks = 0;
    int errors = 0;

    // Reference model: a grant is tracked by its owner, its length and its
    // age in cycles since it was issued; Q is an index into the code list
    logic [2:0] seqTab [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b010};
    bit       mActive = 0;
    int       mWho    = 0;
    int       mLen    = 0;
    int       mAge    = 0;
    int       mPtr    = 0;
    int       mQIdx   = 0;

    count_sched dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .steps0 (steps0),
        .steps1 (steps1),
        .clr    (clr),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_en (cntEn),
        .Q      (q)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic modelStep();
        if (!reset) begin
            mActive = 0;
            mPtr    = 0;
            mQIdx   = 0;
        end else if (mActive) begin
            if (mAge <= mLen) begin
                mQIdx = (mQIdx + 1) % 6;
                if (!req[mWho]) begin
                    mActive = 0;
                    mPtr    = 1 - mWho;
                end else begin
                    mAge++;
                end
            end else begin
                mActive = 0;
                mPtr    = 1 - mWho;
            end
        end else if (clr) begin
            mQIdx = 0;
        end else if (req != 2'b00) begin
            mWho    = req[mPtr] ? mPtr : 1 - mPtr;
            mLen    = (mWho == 1) ? int'(steps1) : int'(steps0);
            mActive = 1;
            mAge    = 1;
        end
    endtask

    task automatic compareAll();
        logic [1:0] expGnt;
        logic [1:0] expDone;
        expGnt  = mActive ? 2'(1 << mWho) : 2'b00;
        expDone = (mActive && mAge == mLen + 1) ? 2'(1 << mWho) : 2'b00;
        checkOutput("gnt",    8'(gnt),   8'(expGnt));
        checkOutput("done",   8'(done),  8'(expDone));
        checkOutput("busy",   8'(busy),  8'(mActive));
        checkOutput("cnt_en", 8'(cntEn), 8'(mActive && mAge <= mLen));
        checkOutput("Q",      8'(q),     8'(seqTab[mQIdx]));
    endtask

    // Drive one cycle of inputs, step the model at the edge, check mid-cycle
    task automatic applyStimulus(input logic r, input logic [1:0] rq,
                                 input logic [2:0] s0, input logic [2:0] s1,
                                 input logic c);
        reset  = r;
        req    = rq;
        steps0 = s0;
        steps1 = s1;
        clr    = c;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    // Directed scenarios first, then a long randomized run
    initial begin
        logic [1:0] prevReq;
        reset = 1'b0; req = 2'b00; steps0 = 3'd0; steps1 = 3'd0; clr = 1'b0;
        @(negedge clk);

        repeat (2) applyStimulus(1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
        repeat (5) applyStimulus(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);

        repeat (5) applyStimulus(1'b1, 2'b01, 3'd3, 3'd0, 1'b0);
        repeat (2) applyStimulus(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);

        repeat (10) applyStimulus(1'b1, 2'b11, 3'd2, 3'd1, 1'b0);
        repeat (3) applyStimulus(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);

        repeat (9) applyStimulus(1'b1, 2'b10, 3'd0, 3'd6, 1'b0);
        repeat (3) applyStimulus(1'b1, 2'b10, 3'd0, 3'd0, 1'b0);
        applyStimulus(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);

        applyStimulus(1'b1, 2'b01, 3'd4, 3'd0, 1'b1);
        repeat (7) applyStimulus(1'b1, 2'b01, 3'd4, 3'd0, 1'b0);

        repeat (2) applyStimulus(1'b1, 2'b01, 3'd5, 3'd0, 1'b0);
        applyStimulus(1'b1, 2'b00, 3'd5, 3'd0, 1'b0);
        repeat (2) applyStimulus(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);

        repeat (3) applyStimulus(1'b1, 2'b10, 3'd0, 3'd7, 1'b0);
        applyStimulus(1'b0, 2'b10, 3'd0, 3'd7, 1'b0);
        applyStimulus(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);

        prevReq = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rq;
            rq = prevReq;
            if ($urandom_range(0, 99) < 8) rq[0] = ~rq[0];
            if ($urandom_range(0, 99) < 8) rq[1] = ~rq[1];
            prevReq = rq;
            applyStimulus(($urandom_range(0, 99) >= 1), rq,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 99) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
